// File: rtl/mem_fetch_unit.sv
// PC, IR and MDR owner for a multi-cycle core.
// Converts fetch/load/store strobes into a req/ack memory access.
module mem_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pcwrite,
    input  logic        branch,
    input  logic [1:0]  pcsrc,
    input  logic        iord,
    input  logic        irwrite,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] aluresult,
    input  logic [31:0] aluout,
    input  logic [31:0] wdata_b,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] data,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        fetch_q, fetch_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic        acc;
    logic        pcen;
    logic [31:0] addr_sel;
    logic [31:0] pc_nxt;

    always_comb begin
        acc      = irwrite | iord;
        addr_sel = irwrite ? pc_q : aluout;
        stall    = acc && (state_q != DONE);
        pcen     = (pcwrite | (branch & zero)) & ~stall;

        case (pcsrc)
            2'b00:   pc_nxt = aluresult;
            2'b01:   pc_nxt = aluout;
            2'b10:   pc_nxt = {pc_q[31:28], instr_q[25:0], 2'b00};
            default: pc_nxt = pc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pcen ? pc_nxt : pc_q;
        instr_d = instr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        we_d    = we_q;
        fetch_d = fetch_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (acc) begin
                    if (addr_sel[1:0] == 2'b00) begin
                        addr_d  = addr_sel;
                        we_d    = memwrite & ~irwrite;
                        wdata_d = wdata_b;
                        fetch_d = irwrite;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                // A late ack on the final wait cycle still wins over timeout
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (fetch_q)    instr_d = mem_rdata;
                    else if (!we_q) data_d  = mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (fetch_q)    instr_d = '0;
                    else if (!we_q) data_d  = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            fetch_q <= fetch_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign instr     = instr_q;
    assign data      = data_q;
    assign err       = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q & req_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Scoreboard bench for mem_fetch_unit: stimulus pushes expected
// access results, a negedge monitor pops them on stall release.
module tb_mem_fetch_unit;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        err;
        int          stall_n;
        int          req_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pcwrite = 1'b0, branch = 1'b0;
    logic [1:0]  pcsrc = 2'b00;
    logic        iord = 1'b0, irwrite = 1'b0, memwrite = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] aluresult = '0, aluout = '0, wdata_b = '0;
    logic [31:0] pc, instr, data, mem_addr, mem_wdata;
    logic        stall, err, mem_req, mem_we;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    exp_t        sbq[$];
    bit          mon_en = 1'b0;
    bit          resp_en = 1'b1;
    int          ack_delay = 0;
    logic [31:0] rdata_v = '0;

    mem_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
        .zero(zero), .aluresult(aluresult), .aluout(aluout),
        .wdata_b(wdata_b), .pc(pc), .instr(instr), .data(data),
        .stall(stall), .err(err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    // Memory model: ack after ack_delay wait cycles (-1 = never)
    int  wcnt = 0;
    bit  acked = 1'b0;
    always @(negedge clk) begin
        if (resp_en) begin
            mem_ack = 1'b0;
            if (mem_req && !acked) begin
                if (wcnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_v;
                    acked     = 1'b1;
                end
                wcnt++;
            end
            if (!mem_req) begin
                wcnt  = 0;
                acked = 1'b0;
            end
        end
    end

    // Monitor
    int          st_n = 0, rq_n = 0;
    bit          prev = 1'b0, unstable = 1'b0;
    bit          pc_pend = 1'b0;
    logic [31:0] pc_exp = '0;
    string       pc_name = "";
    logic [31:0] c_addr = '0, c_wd = '0;
    logic        c_we = 1'b0;

    always @(negedge clk) begin
        if (pc_pend) begin
            chk({pc_name, ".pc"}, pc, pc_exp);
            pc_pend = 1'b0;
        end
        if (!mon_en) begin
            st_n = 0; rq_n = 0; prev = 1'b0; unstable = 1'b0;
        end else begin
            if (mem_req) begin
                if (rq_n == 0) begin
                    c_addr = mem_addr; c_we = mem_we; c_wd = mem_wdata;
                end else if (mem_addr !== c_addr || mem_we !== c_we ||
                             mem_wdata !== c_wd) begin
                    unstable = 1'b1;
                end
                rq_n++;
            end
            if (stall) st_n++;
            if (prev && !stall) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_completion actual=1 required=0");
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk({e.name, ".instr"}, instr, e.instr);
                    chk({e.name, ".data"}, data, e.data);
                    chk({e.name, ".err"}, {31'b0, err}, {31'b0, e.err});
                    chk({e.name, ".stall_n"}, st_n, e.stall_n);
                    chk({e.name, ".req_n"}, rq_n, e.req_n);
                    if (e.req_n > 0) begin
                        chk({e.name, ".addr"}, c_addr, e.addr);
                        chk({e.name, ".we"}, {31'b0, c_we}, {31'b0, e.we});
                        chk({e.name, ".wdata"}, c_wd, e.wdata);
                        chk({e.name, ".stable"}, {31'b0, unstable}, 32'd0);
                    end
                    pc_pend = 1'b1; pc_exp = e.pc; pc_name = e.name;
                end
                st_n = 0; rq_n = 0; unstable = 1'b0;
            end
            prev = stall;
        end
    end

    task automatic access(input exp_t e, input logic irw, input logic io,
                          input logic mw, input logic [31:0] ao,
                          input logic [31:0] wd, input logic pcw,
                          input logic [31:0] ares, input int dly,
                          input logic [31:0] rd);
        bit done = 1'b0;
        @(posedge clk); #1;
        ack_delay = dly; rdata_v = rd;
        sbq.push_back(e);
        irwrite = irw; iord = io; memwrite = mw; aluout = ao;
        wdata_b = wd; pcwrite = pcw; pcsrc = 2'b00; aluresult = ares;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s.wait actual=stalled required=released", e.name);
        end
        @(posedge clk); #1;
        irwrite = 0; iord = 0; memwrite = 0; pcwrite = 0;
    endtask

    task automatic pc_op(input string n, input logic pcw, input logic br,
                         input logic z, input logic [1:0] src,
                         input logic [31:0] ao, input logic [31:0] ares,
                         input logic [31:0] exp_pc);
        @(posedge clk); #1;
        pcwrite = pcw; branch = br; zero = z; pcsrc = src;
        aluout = ao; aluresult = ares;
        chk({n, ".stall"}, {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk({n, ".pc"}, pc, exp_pc);
        pcwrite = 0; branch = 0; zero = 0; pcsrc = 2'b00;
    endtask

    initial begin
        bit drained;
        irwrite = 1'b1;
        #3;
        chk("rst.stall_fetch", {31'b0, stall}, 32'd1);
        irwrite = 1'b0;
        #1;
        chk("rst.stall_idle", {31'b0, stall}, 32'd0);
        chk("rst.pc", pc, 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.data", data, 32'h0);
        chk("rst.req", {31'b0, mem_req}, 32'd0);
        chk("rst.err", {31'b0, err}, 32'd0);
        #10 reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        access('{"fetch0", 32'h8C01_0004, 32'h0, 32'h4, 32'h0, 32'h0,
                 1'b0, 1'b0, 2, 1},
               1, 0, 0, 32'h0, 32'h0, 1, 32'h4, 0, 32'h8C01_0004);
        access('{"load3w", 32'h8C01_0004, 32'hDEAD_BEEF, 32'h4, 32'h40,
                 32'h0, 1'b0, 1'b0, 5, 4},
               0, 1, 0, 32'h40, 32'h0, 0, 32'h0, 3, 32'hDEAD_BEEF);
        access('{"store", 32'h8C01_0004, 32'hDEAD_BEEF, 32'h4, 32'h44,
                 32'h1234_5678, 1'b1, 1'b0, 3, 2},
               0, 1, 1, 32'h44, 32'h1234_5678, 0, 32'h0, 1, 32'hFFFF_0000);

        pc_op("br_taken", 0, 1, 1, 2'b01, 32'h100, 32'h0, 32'h100);
        pc_op("br_nottaken", 0, 1, 0, 2'b01, 32'h200, 32'h0, 32'h100);
        pc_op("pcw_alu", 1, 0, 0, 2'b00, 32'h0, 32'h8, 32'h8);

        access('{"fetch8", 32'h0800_0010, 32'hDEAD_BEEF, 32'h8, 32'h8,
                 32'h0, 1'b0, 1'b0, 2, 1},
               1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0800_0010);
        pc_op("jump", 1, 0, 0, 2'b10, 32'h0, 32'h0, 32'h40);
        pc_op("hold", 1, 0, 0, 2'b11, 32'h80, 32'h84, 32'h40);

        access('{"misalign", 32'h0800_0010, 32'hDEAD_BEEF, 32'h40, 32'h0,
                 32'h0, 1'b0, 1'b1, 1, 0},
               0, 1, 0, 32'h42, 32'h0, 0, 32'h0, 0, 32'h0);
        access('{"timeout", 32'h0, 32'hDEAD_BEEF, 32'h40, 32'h40,
                 32'h0, 1'b0, 1'b1, 5, 4},
               1, 0, 0, 32'h0, 32'h0, 0, 32'h0, -1, 32'h5555_5555);

        drained = 1'b0;
        for (int i = 0; i < 50 && !drained; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !pc_pend) drained = 1'b1;
        end
        chk("sb.drained", {31'b0, drained}, 32'd1);

        // Reset in the middle of an outstanding fetch
        mon_en = 1'b0;
        resp_en = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        irwrite = 1'b1;
        @(posedge clk); #1;
        chk("midrst.req_before", {31'b0, mem_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst.req", {31'b0, mem_req}, 32'd0);
        chk("midrst.pc", pc, 32'h0);
        chk("midrst.err", {31'b0, err}, 32'd0);
        chk("midrst.stall", {31'b0, stall}, 32'd1);
        irwrite = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        mem_rdata = 32'hFFFF_FFFF;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("lateack.instr", instr, 32'h0);
        chk("lateack.req", {31'b0, mem_req}, 32'd0);
        chk("lateack.stall", {31'b0, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_fetch_unit.md
Name: mem_fetch_unit

Overview:
- Sits between the multi-cycle control FSM and the unified instruction/data memory.
- Owns the PC, the instruction register (IR) and the memory data register (MDR).
- Turns the controller's fetch/load/store strobes into a req/ack handshake with a variable-latency memory.
- Asserts stall back to the controller until each access completes; the controller holds its state while stall=1.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 255, max cycles in REQ without mem_ack before the access is force-completed with a bus error (1..65535).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pcwrite  in  1  unconditional PC update strobe from controller.
- branch  in  1  conditional PC update strobe (taken when zero=1).
- pcsrc  in  2  next-PC select.
- iord  in  1  0 = instruction address (pc), 1 = data address (aluout).
- irwrite  in  1  instruction fetch request.
- memwrite  in  1  store request (valid with iord=1).
- zero  in  1  ALU zero flag.
- aluresult  in  32  combinational ALU result.
- aluout  in  32  registered ALU result / effective address.
- wdata_b  in  32  store data (register B).
- pc  out  32  program counter.
- instr  out  32  instruction register.
- data  out  32  memory data register.
- stall  out  1  access pending; controller must hold its state.
- err  out  1  sticky error flag (misaligned access or timeout).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle access completion from memory.

Behaviour:
- Access demand: acc = irwrite | iord. Access type:
  - fetch: irwrite=1.
  - load: iord=1 and memwrite=0.
  - store: iord=1 and memwrite=1.
  - irwrite=1 together with iord=1 is illegal; irwrite takes priority.
- FSM states IDLE, REQ, DONE. Reset state is IDLE.
- IDLE:
  - If acc=1 and the selected address has [1:0]==0: latch mem_addr (iord ? aluout : pc), mem_we=memwrite&iord, mem_wdata=wdata_b; set mem_req=1; go to REQ.
  - If acc=1 and the address is misaligned: set err, issue no request, go to DONE.
- REQ:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable.
  - On mem_ack=1: fetch writes mem_rdata to instr; load writes mem_rdata to data; store writes nothing. mem_req drops the next cycle; go to DONE.
  - When the wait counter reaches TIMEOUT: set err, drop mem_req, load 0 into instr (fetch) or data (load), go to DONE.
- DONE: one cycle, then IDLE.
- stall = acc & (state != DONE). This is combinational.
- Latency: an access with zero-wait memory (ack in the first REQ cycle) costs 3 cycles (IDLE, REQ, DONE). Each wait cycle adds 1.
- PC update:
  - pcen = (pcwrite | (branch & zero)) & ~stall.
  - next PC by pcsrc: 00 = aluresult; 01 = aluout; 10 = {pc[31:28], instr[25:0], 2'b00}; 11 = hold.
  - In a fetch cycle the PC therefore updates only in DONE, in the same edge that the controller leaves FETCH.
  - With acc=0, pcen takes effect the same cycle (branch and jump execute states).
- mem_ack outside REQ is ignored.
- err is sticky until reset.
- Reset (async, any state): pc=RESET_PC, instr=0, data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, counter=0, state=IDLE.
  - An ack that arrives after a mid-access reset is ignored.
  - stall after reset follows acc; it is 1 immediately when the controller is in FETCH.
- Expected size: 150-250 lines of RTL.

Test Plan:
- Zero-wait fetch: reset, RESET_PC=0, controller FETCH (irwrite=1, pcwrite=1, pcsrc=00, aluresult=4), mem_ack in the first REQ cycle with mem_rdata=32'h8C01_0004 -> stall=1 for 2 cycles; instr=32'h8C01_0004; pc=4 after DONE; mem_addr=0, mem_we=0.
- Load with 3 wait states: iord=1, memwrite=0, aluout=32'h40, ack on the 4th REQ cycle with rdata=32'hDEAD_BEEF -> mem_req high 4 cycles; data=32'hDEAD_BEEF; stall high 5 cycles; pc unchanged.
- Store: iord=1, memwrite=1, aluout=32'h44, wdata_b=32'h1234_5678 -> mem_we=1, mem_addr=32'h44, mem_wdata=32'h1234_5678 held until ack; data unchanged.
- Branch/jump without access: branch=1, zero=1, pcsrc=01, aluout=32'h100 -> pc=32'h100 next edge, stall=0. Same with zero=0 -> pc held. pcsrc=10, pc=32'h0000_0008, instr[25:0]=26'h10 -> pc=32'h40.
- Errors: misaligned load with aluout=32'h42 -> no mem_req, err=1, stall released after 1 cycle. With TIMEOUT=4 and no ack -> mem_req dropped after 4 REQ cycles, err=1, instr=0.
- Reset mid-REQ: deassert reset_n while mem_req=1 -> mem_req=0 and pc=RESET_PC asynchronously; a late mem_ack after release leaves instr=0.
